dual_stack_arbiter: RTL and testbench
=====================================

Name: dual_stack_arbiter

Overview:
Shares one single-port simple RAM (2**DEPTH_LOG words) between two independent LIFO stacks, A and B. Stack A grows upward from address 0; stack B grows downward from address DEPTH-1. Each cycle the block round-robin arbitrates the two requesters and issues at most one RAM access. It sits between two stack clients and one pkg_simple_ram instance and replaces two separate stack RAMs.

Parameters:
WIDTH, 8, data word width in bits
DEPTH_LOG, 4, log2 of shared RAM depth; DEPTH = 2**DEPTH_LOG words shared by both stacks

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
a_push_req  input  1  stack A push request; held until granted
a_pop_req  input  1  stack A pop request; held until granted
a_push_data  input  WIDTH  stack A push data
a_gnt  output  1  stack A request accepted this cycle (combinational)
a_pop_valid  output  1  a_pop_data valid (one cycle after pop grant)
a_pop_data  output  WIDTH  stack A popped word
a_empty  output  1  stack A holds no words
a_count  output  DEPTH_LOG+1  stack A occupancy
b_push_req, b_pop_req, b_push_data, b_gnt, b_pop_valid, b_pop_data, b_empty, b_count  same as A, for stack B
full  output  1  a_count + b_count == DEPTH
ram_write_req  output  1  RAM write enable
ram_addr  output  DEPTH_LOG  RAM address
ram_write_data  output  WIDTH  RAM write data
ram_read_data  input  WIDTH  RAM q; registered, valid one cycle after address

Behaviour:
- Reset (async, rst_n=0): a_count=b_count=0, a_empty=b_empty=1, full=0, a/b_pop_valid=0, last-grant register=B (A wins first contention), a_gnt=b_gnt=0.
- Per-port op: push takes priority if push_req and pop_req are both high; pop_req is then ignored that cycle.
- An op is eligible only if legal: push needs full=0; pop needs that stack nonempty. Illegal requests get no grant, no RAM access, no count change.
- Arbitration: if exactly one port is eligible, it is granted. If both are eligible, the port not granted last time is granted. The last-grant register updates only on a grant. gnt is combinational from req, counts and the last-grant register.
- Handshake: the transfer completes on the rising edge where req & gnt. The requester holds req and data stable until then.
- Push A: ram_write_req=1, ram_addr=a_count, ram_write_data=a_push_data; a_count+1 at the edge.
- Push B: ram_addr=DEPTH-1-b_count; b_count+1.
- Pop A: ram_write_req=0, ram_addr=a_count-1; a_count-1 at the edge. a_pop_valid=1 in the following cycle, with a_pop_data=ram_read_data.
- Pop B: ram_addr=DEPTH-b_count; b_count-1.
- pop_data for both ports is the shared ram_read_data, qualified only by the respective pop_valid.
- Idle cycle: ram_write_req=0, ram_addr=0, ram_write_data=0.
- Width rules:
  - counts are DEPTH_LOG+1 bits; the sum is computed in DEPTH_LOG+1 bits (max DEPTH, no overflow).
  - Addresses are truncated to DEPTH_LOG bits after the subtraction.
- Boundaries:
  - Either stack may take all DEPTH words when the other is empty.
  - When full=1, no push is granted on either port; pops still proceed.
  - A pop grant in the same cycle as full=1 clears full at the next edge.
  - Pointers never cross; no wrap-around exists.
- Back-to-back pops are supported, one per granted cycle. pop_valid pulses are single-cycle per grant.
- Reset mid-operation: a pending pop_valid is cleared and all counts return to 0. RAM contents are not cleared but are logically discarded.

Decomposition:
- Shared package (dual_stack_pkg): op encoding OP_IDLE/OP_PUSH/OP_POP; owner encoding OWN_A/OWN_B; address helper functions for A-top and B-top address calculation.
- One sub-module: rr_arbiter_2, a two-requester round-robin arbiter with a last-grant register, reset to favour requester 0.

Test Plan (DEPTH_LOG=2, WIDTH=8):
1. After reset, A pushes 0x11 then 0x22 -> ram writes at addr 0, 1; a_count=2. A pops -> ram_addr=1 with ram_write_req=0; next cycle a_pop_valid=1, a_pop_data=0x22; a_count=1.
2. B pushes 0xA0, 0xA1 -> writes at addr 3, 2. B pops -> addr 2, b_pop_data=0xA1; b_count=1.
3. A and B both push continuously from reset -> grants A, B, A, B. Writes land at addr 0, 3, 1, 2. full=1 after the 4th push; subsequent pushes get a_gnt=b_gnt=0 and no RAM write.
4. a_pop_req=1 with a_count=0 while B idle -> a_gnt=0, ram_write_req=0, a_count stays 0, a_pop_valid never asserts.
5. With full=1, A pushes and B pops in the same cycle -> only B granted (pop at addr 2). Next cycle full=0 and A's held push is granted at addr 2.
6. A pop granted, then rst_n=0 in the following cycle -> a_pop_valid=0, a_count=b_count=0, a_empty=1. The first contention after reset is granted to A.

Source files
------------

// File: rtl/dual_stack_pkg.sv
// Shared types and address helpers for the dual-stack arbiter.
// The address helpers work on 32-bit values; callers truncate to the RAM address width.
package dual_stack_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2
    } op_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // Push wins over pop even when the push itself is illegal (full).
    function automatic op_e legal_op(input logic push_req, input logic pop_req,
                                     input logic full, input logic empty);
        op_e op;
        if (push_req) begin
            op = full ? OP_IDLE : OP_PUSH;
        end else if (pop_req && !empty) begin
            op = OP_POP;
        end else begin
            op = OP_IDLE;
        end
        return op;
    endfunction

    function automatic logic [31:0] a_top_addr(input logic [31:0] count, input op_e op);
        return (op == OP_PUSH) ? count : count - 32'd1;
    endfunction

    function automatic logic [31:0] b_top_addr(input logic [31:0] depth, input logic [31:0] count,
                                               input op_e op);
        return (op == OP_PUSH) ? depth - 32'd1 - count : depth - count;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; requester 0 wins the first contention after reset.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_r;

    // Grant selection: a lone requester wins, contention goes to the one not granted last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_r ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Last-grant register; only moves when something is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/dual_stack_arbiter.sv
// Two LIFO stacks sharing one single-port RAM: A grows up from 0, B grows down from DEPTH-1.
// At most one RAM access per cycle, chosen by a round-robin arbiter among legal requests.
module dual_stack_arbiter
    import dual_stack_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_push_req,
    input  logic                 a_pop_req,
    input  logic [WIDTH-1:0]     a_push_data,
    output logic                 a_gnt,
    output logic                 a_pop_valid,
    output logic [WIDTH-1:0]     a_pop_data,
    output logic                 a_empty,
    output logic [DEPTH_LOG:0]   a_count,
    input  logic                 b_push_req,
    input  logic                 b_pop_req,
    input  logic [WIDTH-1:0]     b_push_data,
    output logic                 b_gnt,
    output logic                 b_pop_valid,
    output logic [WIDTH-1:0]     b_pop_data,
    output logic                 b_empty,
    output logic [DEPTH_LOG:0]   b_count,
    output logic                 full,
    output logic                 ram_write_req,
    output logic [DEPTH_LOG-1:0] ram_addr,
    output logic [WIDTH-1:0]     ram_write_data,
    input  logic [WIDTH-1:0]     ram_read_data
);

    localparam int CW = DEPTH_LOG + 1;
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_W   = CW'(1);
    localparam logic [CW-1:0] ZERO_W  = CW'(0);

    logic [CW-1:0] a_count_r, b_count_r;
    logic          a_pop_valid_r, b_pop_valid_r;
    logic          full_s, a_empty_s, b_empty_s;
    op_e           a_op_s, b_op_s, sel_op_s;
    owner_e        owner_s;
    logic [1:0]    req_s, gnt_s;

    assign full_s    = (a_count_r + b_count_r) == DEPTH_W;
    assign a_empty_s = (a_count_r == ZERO_W);
    assign b_empty_s = (b_count_r == ZERO_W);
    assign a_op_s    = legal_op(a_push_req, a_pop_req, full_s, a_empty_s);
    assign b_op_s    = legal_op(b_push_req, b_pop_req, full_s, b_empty_s);
    // Requests are masked while reset is held so no grant or RAM access leaks out.
    assign req_s     = {(b_op_s != OP_IDLE) && rst_n, (a_op_s != OP_IDLE) && rst_n};

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_s),
        .gnt   (gnt_s)
    );

    // Resolve which stack owns the RAM this cycle and what it does with it.
    always_comb begin
        owner_s  = OWN_A;
        sel_op_s = OP_IDLE;
        if (gnt_s[0]) begin
            owner_s  = OWN_A;
            sel_op_s = a_op_s;
        end else if (gnt_s[1]) begin
            owner_s  = OWN_B;
            sel_op_s = b_op_s;
        end else begin
            owner_s  = OWN_A;
            sel_op_s = OP_IDLE;
        end
    end

    // RAM command drive; idle cycles present all-zero address and data.
    always_comb begin
        ram_write_req  = 1'b0;
        ram_addr       = {DEPTH_LOG{1'b0}};
        ram_write_data = {WIDTH{1'b0}};
        if (sel_op_s != OP_IDLE) begin
            ram_write_req = (sel_op_s == OP_PUSH);
            case (owner_s)
                OWN_A: begin
                    ram_addr       = DEPTH_LOG'(a_top_addr(32'(a_count_r), sel_op_s));
                    ram_write_data = (sel_op_s == OP_PUSH) ? a_push_data : {WIDTH{1'b0}};
                end
                OWN_B: begin
                    ram_addr       = DEPTH_LOG'(b_top_addr(32'(DEPTH), 32'(b_count_r), sel_op_s));
                    ram_write_data = (sel_op_s == OP_PUSH) ? b_push_data : {WIDTH{1'b0}};
                end
                default: begin
                    ram_addr       = {DEPTH_LOG{1'b0}};
                    ram_write_data = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            ram_write_req = 1'b0;
        end
    end

    // Occupancy counters and one-cycle pop-valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count_r     <= ZERO_W;
            b_count_r     <= ZERO_W;
            a_pop_valid_r <= 1'b0;
            b_pop_valid_r <= 1'b0;
        end else begin
            if (gnt_s[0] && (a_op_s == OP_PUSH)) begin
                a_count_r <= a_count_r + ONE_W;
            end else if (gnt_s[0] && (a_op_s == OP_POP)) begin
                a_count_r <= a_count_r - ONE_W;
            end else begin
                a_count_r <= a_count_r;
            end
            if (gnt_s[1] && (b_op_s == OP_PUSH)) begin
                b_count_r <= b_count_r + ONE_W;
            end else if (gnt_s[1] && (b_op_s == OP_POP)) begin
                b_count_r <= b_count_r - ONE_W;
            end else begin
                b_count_r <= b_count_r;
            end
            a_pop_valid_r <= gnt_s[0] && (a_op_s == OP_POP);
            b_pop_valid_r <= gnt_s[1] && (b_op_s == OP_POP);
        end
    end

    assign a_gnt       = gnt_s[0];
    assign b_gnt       = gnt_s[1];
    assign a_count     = a_count_r;
    assign b_count     = b_count_r;
    assign a_empty     = a_empty_s;
    assign b_empty     = b_empty_s;
    assign full        = full_s;
    assign a_pop_valid = a_pop_valid_r;
    assign b_pop_valid = b_pop_valid_r;
    assign a_pop_data  = ram_read_data;
    assign b_pop_data  = ram_read_data;

endmodule

// File: tb/tb_dual_stack_arbiter.sv
// Directed bench for dual_stack_arbiter: queue-based stack model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_dual_stack_arbiter;

    localparam int W  = 8;
    localparam int DL = 2;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_push_req, a_pop_req, b_push_req, b_pop_req;
    logic [W-1:0]  a_push_data, b_push_data;
    logic          a_gnt, b_gnt, a_pop_valid, b_pop_valid, a_empty, b_empty, full;
    logic [W-1:0]  a_pop_data, b_pop_data;
    logic [DL:0]   a_count, b_count;
    logic          ram_write_req;
    logic [DL-1:0] ram_addr;
    logic [W-1:0]  ram_write_data;
    logic [W-1:0]  ram_read_data;

    dual_stack_arbiter #(.WIDTH(W), .DEPTH_LOG(DL)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_push_req(a_push_req), .a_pop_req(a_pop_req), .a_push_data(a_push_data),
        .a_gnt(a_gnt), .a_pop_valid(a_pop_valid), .a_pop_data(a_pop_data),
        .a_empty(a_empty), .a_count(a_count),
        .b_push_req(b_push_req), .b_pop_req(b_pop_req), .b_push_data(b_push_data),
        .b_gnt(b_gnt), .b_pop_valid(b_pop_valid), .b_pop_data(b_pop_data),
        .b_empty(b_empty), .b_count(b_count),
        .full(full), .ram_write_req(ram_write_req), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    // Simple single-port RAM with registered read data.
    logic [W-1:0] mem [0:D-1];
    always @(posedge clk) begin
        if (ram_write_req) mem[ram_addr] <= ram_write_data;
        ram_read_data <= mem[ram_addr];
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each stack is a queue of the words it holds.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    bit           last_b = 1'b1;
    bit           epv_a = 1'b0, epv_b = 1'b0;
    logic [W-1:0] epd_a, epd_b;

    always begin : cmp
        int na, nb, ea, eb;
        bit full_e, ga, gb, we_e;
        int addr_e;
        logic [W-1:0] wd_e;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            last_b = 1'b1;
            epv_a  = 1'b0;
            epv_b  = 1'b0;
            chk("rst a_count", a_count, 0);
            chk("rst b_count", b_count, 0);
            chk("rst a_empty", a_empty, 1);
            chk("rst b_empty", b_empty, 1);
            chk("rst full", full, 0);
            chk("rst a_pop_valid", a_pop_valid, 0);
            chk("rst b_pop_valid", b_pop_valid, 0);
            chk("rst a_gnt", a_gnt, 0);
            chk("rst b_gnt", b_gnt, 0);
        end else begin
            na = qa.size();
            nb = qb.size();
            full_e = (na + nb == D);
            // 0 = nothing legal, 1 = push, 2 = pop
            ea = a_push_req ? (full_e ? 0 : 1) : ((a_pop_req && na > 0) ? 2 : 0);
            eb = b_push_req ? (full_e ? 0 : 1) : ((b_pop_req && nb > 0) ? 2 : 0);
            ga = (ea != 0) && ((eb == 0) || last_b);
            gb = (eb != 0) && !ga;
            we_e = 1'b0; addr_e = 0; wd_e = 8'h00;
            if (ga) begin
                we_e   = (ea == 1);
                addr_e = (ea == 1) ? na : na - 1;
                wd_e   = (ea == 1) ? a_push_data : 8'h00;
            end else if (gb) begin
                we_e   = (eb == 1);
                addr_e = (eb == 1) ? D - 1 - nb : D - nb;
                wd_e   = (eb == 1) ? b_push_data : 8'h00;
            end
            chk("a_gnt", a_gnt, ga);
            chk("b_gnt", b_gnt, gb);
            chk("ram_write_req", ram_write_req, we_e);
            chk("ram_addr", ram_addr, addr_e);
            chk("ram_write_data", ram_write_data, wd_e);
            chk("a_count", a_count, na);
            chk("b_count", b_count, nb);
            chk("a_empty", a_empty, na == 0);
            chk("b_empty", b_empty, nb == 0);
            chk("full", full, full_e);
            chk("a_pop_valid", a_pop_valid, epv_a);
            chk("b_pop_valid", b_pop_valid, epv_b);
            if (epv_a) chk("a_pop_data", a_pop_data, epd_a);
            if (epv_b) chk("b_pop_data", b_pop_data, epd_b);
            @(posedge clk);
            epv_a = 1'b0;
            epv_b = 1'b0;
            if (ga) begin
                last_b = 1'b0;
                if (ea == 1) qa.push_back(a_push_data);
                else begin epd_a = qa.pop_back(); epv_a = 1'b1; end
            end
            if (gb) begin
                last_b = 1'b1;
                if (eb == 1) qb.push_back(b_push_data);
                else begin epd_b = qb.pop_back(); epv_b = 1'b1; end
            end
        end
    end

    task automatic cyc(input logic ap, input logic aq, input logic [W-1:0] ad,
                       input logic bp, input logic bq, input logic [W-1:0] bd);
        @(negedge clk);
        a_push_req = ap; a_pop_req = aq; a_push_data = ad;
        b_push_req = bp; b_pop_req = bq; b_push_data = bd;
        #3;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_push_req = 1'b0; a_pop_req = 1'b0; b_push_req = 1'b0; b_pop_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_push_req = 1'b0; a_pop_req = 1'b0; a_push_data = 8'h00;
        b_push_req = 1'b0; b_pop_req = 1'b0; b_push_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Stack A push/pop
        cyc(1, 0, 8'h11, 0, 0, 8'h00);
        chk("t1 push0 gnt", a_gnt, 1); chk("t1 push0 we", ram_write_req, 1); chk("t1 push0 addr", ram_addr, 0);
        cyc(1, 0, 8'h22, 0, 0, 8'h00);
        chk("t1 push1 addr", ram_addr, 1); chk("t1 push1 wd", ram_write_data, 8'h22);
        cyc(0, 1, 8'h00, 0, 0, 8'h00);
        chk("t1 pop we", ram_write_req, 0); chk("t1 pop addr", ram_addr, 1);
        idle();
        chk("t1 pop valid", a_pop_valid, 1); chk("t1 pop data", a_pop_data, 8'h22); chk("t1 count", a_count, 1);
        cyc(0, 1, 8'h00, 0, 0, 8'h00);
        chk("t1 pop2 addr", ram_addr, 0);
        idle();
        chk("t1 pop2 data", a_pop_data, 8'h11); chk("t1 empty", a_empty, 1);

        // Stack B push/pop
        cyc(0, 0, 8'h00, 1, 0, 8'hA0);
        chk("t2 push0 gnt", b_gnt, 1); chk("t2 push0 addr", ram_addr, 3);
        cyc(0, 0, 8'h00, 1, 0, 8'hA1);
        chk("t2 push1 addr", ram_addr, 2);
        cyc(0, 0, 8'h00, 0, 1, 8'h00);
        chk("t2 pop addr", ram_addr, 2); chk("t2 pop we", ram_write_req, 0);
        idle();
        chk("t2 pop valid", b_pop_valid, 1); chk("t2 pop data", b_pop_data, 8'hA1); chk("t2 count", b_count, 1);
        cyc(0, 0, 8'h00, 0, 1, 8'h00);
        chk("t2 pop2 addr", ram_addr, 3);
        idle();
        chk("t2 pop2 data", b_pop_data, 8'hA0);

        // Contention from reset, fill to full, then full-cycle pop/push
        do_reset();
        cyc(1, 0, 8'hC0, 1, 0, 8'hD0);
        chk("t3 g1 a", a_gnt, 1); chk("t3 g1 b", b_gnt, 0); chk("t3 g1 addr", ram_addr, 0);
        cyc(1, 0, 8'hC1, 1, 0, 8'hD0);
        chk("t3 g2 b", b_gnt, 1); chk("t3 g2 addr", ram_addr, 3);
        cyc(1, 0, 8'hC1, 1, 0, 8'hD1);
        chk("t3 g3 a", a_gnt, 1); chk("t3 g3 addr", ram_addr, 1);
        cyc(1, 0, 8'hC2, 1, 0, 8'hD1);
        chk("t3 g4 b", b_gnt, 1); chk("t3 g4 addr", ram_addr, 2);
        cyc(1, 0, 8'hC2, 1, 0, 8'hD2);
        chk("t3 full", full, 1); chk("t3 full a_gnt", a_gnt, 0); chk("t3 full b_gnt", b_gnt, 0);
        chk("t3 full we", ram_write_req, 0);
        cyc(1, 0, 8'hC2, 0, 1, 8'h00);
        chk("t5 pop b_gnt", b_gnt, 1); chk("t5 pop a_gnt", a_gnt, 0); chk("t5 pop addr", ram_addr, 2);
        cyc(1, 0, 8'hC2, 0, 0, 8'h00);
        chk("t5 full cleared", full, 0); chk("t5 push a_gnt", a_gnt, 1); chk("t5 push addr", ram_addr, 2);
        chk("t5 pop data", b_pop_data, 8'hD1);
        cyc(1, 1, 8'hC3, 0, 0, 8'h00);
        chk("t5 push-over-pop gnt", a_gnt, 0);

        // Pop from empty stack, then B takes the whole RAM
        do_reset();
        cyc(0, 1, 8'h00, 0, 0, 8'h00);
        chk("t4 gnt", a_gnt, 0); chk("t4 we", ram_write_req, 0);
        cyc(0, 1, 8'h00, 0, 0, 8'h00);
        chk("t4 count", a_count, 0); chk("t4 valid", a_pop_valid, 0);
        idle();
        chk("t4 valid2", a_pop_valid, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, 0, 8'hE0 + 8'(i));
        chk("t4 b last addr", ram_addr, 0);
        cyc(1, 0, 8'hF0, 1, 0, 8'hE4);
        chk("t4 b full", full, 1); chk("t4 full b_gnt", b_gnt, 0); chk("t4 full a_gnt", a_gnt, 0);
        chk("t4 b_count", b_count, 4);

        // Reset right after a pop grant
        do_reset();
        cyc(1, 0, 8'h5A, 0, 0, 8'h00);
        cyc(0, 1, 8'h00, 0, 0, 8'h00);
        chk("t6 pop gnt", a_gnt, 1);
        @(negedge clk);
        rst_n = 1'b0;
        a_push_req = 1'b0; a_pop_req = 1'b0;
        #3;
        chk("t6 rst valid", a_pop_valid, 0); chk("t6 rst count", a_count, 0); chk("t6 rst empty", a_empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 8'h66, 1, 0, 8'h77);
        chk("t6 first a_gnt", a_gnt, 1); chk("t6 first b_gnt", b_gnt, 0); chk("t6 first addr", ram_addr, 0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
